// File: rtl/alarm_timer_bank.sv
// Bank of independent down-counting timers sharing one prescaler.
// Each channel runs one-shot or periodic and pulses clkFinish on expiry.
module alarm_timer_bank #(
  parameter int WIDTH    = 18,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1
) (
  input  logic                      clkSignal,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS*WIDTH-1:0] maxCount,
  output logic [CHANNELS-1:0]       clkFinish,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*WIDTH-1:0] remaining
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [PS_W-1:0] presc_q, presc_d;
  logic            tick;

  // Shared free-running prescaler; starting a channel never realigns it.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (EN) begin
      if (presc_q == PS_MAX) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clkSignal or posedge RST) begin
    if (RST) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             fin_q, fin_d;
    logic [WIDTH-1:0] load_val;

    assign load_val = maxCount[i*WIDTH +: WIDTH];

    // Priority: stop (or a zero-length start) > start > tick.
    always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      fin_d    = 1'b0;
      if (stop[i] || (start[i] && (load_val == '0))) begin
        state_d = IDLE;
        count_d = '0;
      end else if (start[i]) begin
        state_d  = RUN;
        count_d  = load_val;
        reload_d = load_val;
        mode_d   = periodic[i];
      end else if ((state_q == RUN) && tick) begin
        if (count_q == WIDTH'(1)) begin
          fin_d = 1'b1;
          if (mode_q) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end

    always_ff @(posedge clkSignal or posedge RST) begin
      if (RST) begin
        state_q  <= IDLE;
        count_q  <= '0;
        reload_q <= '0;
        mode_q   <= 1'b0;
        fin_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        count_q  <= count_d;
        reload_q <= reload_d;
        mode_q   <= mode_d;
        fin_q    <= fin_d;
      end
    end

    assign clkFinish[i]                 = fin_q;
    assign busy[i]                      = (state_q == RUN);
    assign remaining[i*WIDTH +: WIDTH]  = count_q;
  end

endmodule

// File: tb/tb_alarm_timer_bank.sv
// Scoreboard bench for alarm_timer_bank: expected expiry cycles are queued
// at stimulus time and matched by a monitor watching clkFinish.
module tb_alarm_timer_bank;

  localparam int W  = 18;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            RST;
  logic            en1, en4;
  logic [CH-1:0]   start1, stop1, per1, start4, stop4, per4;
  logic [CH*W-1:0] max1, max4;
  logic [CH-1:0]   fin1, busy1, fin4, busy4;
  logic [CH*W-1:0] rem1, rem4;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_q [8][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alarm_timer_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(1)) u1 (
    .clkSignal(clk), .RST(RST), .EN(en1), .start(start1), .stop(stop1),
    .periodic(per1), .maxCount(max1), .clkFinish(fin1), .busy(busy1),
    .remaining(rem1)
  );

  alarm_timer_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(4)) u4 (
    .clkSignal(clk), .RST(RST), .EN(en4), .start(start4), .stop(stop4),
    .periodic(per4), .maxCount(max4), .clkFinish(fin4), .busy(busy4),
    .remaining(rem4)
  );

  // Monitor: indices 0-3 are u1 channels, 4-7 are u4 channels.
  always @(negedge clk) begin
    logic [7:0] fins;
    fins = {fin4, fin1};
    for (int k = 0; k < 8; k++) begin
      if (exp_q[k].size() > 0 && exp_q[k][0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse idx=%0d: no pulse seen, required at cycle %0d (now %0d)",
                 k, exp_q[k][0], cyc);
        void'(exp_q[k].pop_front());
      end
      if (fins[k]) begin
        checks++;
        if (exp_q[k].size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse idx=%0d: pulse at cycle %0d, none required", k, cyc);
        end else begin
          int e;
          e = exp_q[k].pop_front();
          if (e != cyc) begin
            errors++;
            $display("FAIL pulse_time idx=%0d: pulse at cycle %0d, required %0d", k, cyc, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    start1 = '0; stop1 = '0; start4 = '0; stop4 = '0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic go1(input int ch, input logic [W-1:0] m, input logic p);
    start1[ch]       = 1'b1;
    max1[ch*W +: W]  = m;
    per1[ch]         = p;
  endtask

  int d;

  initial begin
    RST = 1'b1; en1 = 1'b1; en4 = 1'b0;
    start1 = '0; stop1 = '0; per1 = '0; max1 = '0;
    start4 = '0; stop4 = '0; per4 = '0; max4 = '0;
    repeat (3) @(negedge clk);
    chk("reset_fin",  {fin4, fin1}, 0);
    chk("reset_busy", {busy4, busy1}, 0);
    chk("reset_rem1", rem1, 0);
    RST = 1'b0;
    step();

    // One-shot ch0, M=5
    d = cyc;
    go1(0, 5, 1'b0);
    exp_q[0].push_back(d + 6);
    step();
    chk("os_busy_rise", busy1[0], 1);
    chk("os_rem_load", rem1[0 +: W], 5);
    wait_until(d + 4);
    chk("os_rem_mid", rem1[0 +: W], 2);
    wait_until(d + 6);
    chk("os_busy_fall", busy1[0], 0);
    chk("os_rem_end", rem1[0 +: W], 0);
    wait_until(d + 14);

    // Periodic ch1, M=3, ten periods then stop mid-period
    d = cyc;
    go1(1, 3, 1'b1);
    for (int k = 1; k <= 10; k++) exp_q[1].push_back(d + 1 + 3 * k);
    step();
    wait_until(d + 32);
    chk("per_rem_mid", rem1[W +: W], 2);
    stop1[1] = 1'b1;
    step();
    chk("per_stop_busy", busy1[1], 0);
    chk("per_stop_rem", rem1[W +: W], 0);
    wait_until(d + 42);

    // Restart ch0 on its expiry cycle: pulse discarded, new one 7 later
    d = cyc;
    go1(0, 4, 1'b0);
    step();
    wait_until(d + 4);
    go1(0, 7, 1'b0);
    exp_q[0].push_back(d + 12);
    step();
    chk("restart_rem", rem1[0 +: W], 7);
    chk("restart_busy", busy1[0], 1);
    wait_until(d + 15);

    // Simultaneous start+stop on a running channel
    go1(2, 5, 1'b0);
    step(); step();
    go1(2, 9, 1'b1);
    stop1[2] = 1'b1;
    step();
    chk("startstop_busy", busy1[2], 0);
    chk("startstop_rem", rem1[2*W +: W], 0);
    repeat (8) step();

    // maxCount=0 start: idle and acts as stop on a running channel
    go1(3, 0, 1'b0);
    step();
    chk("zero_busy", busy1[3], 0);
    go1(3, 10, 1'b0);
    step();
    chk("zero_pre_busy", busy1[3], 1);
    go1(3, 0, 1'b1);
    step();
    chk("zero_stop_busy", busy1[3], 0);
    chk("zero_stop_rem", rem1[3*W +: W], 0);

    // Full-scale load decrements from all-ones
    go1(3, 18'h3FFFF, 1'b0);
    step();
    chk("max_load", rem1[3*W +: W], 18'h3FFFF);
    step();
    chk("max_dec1", rem1[3*W +: W], 18'h3FFFE);
    repeat (3) step();
    chk("max_dec4", rem1[3*W +: W], 18'h3FFFB);
    stop1[3] = 1'b1;
    step();
    chk("max_stop", rem1[3*W +: W], 0);
    repeat (3) step();

    // Prescaler 4: ch2 M=2 periodic, EN held low 5 cycles
    d = cyc;
    start4[2] = 1'b1; max4[2*W +: W] = 2; per4[2] = 1'b1; en4 = 1'b1;
    exp_q[6].push_back(d + 8);
    exp_q[6].push_back(d + 16);
    exp_q[6].push_back(d + 29);
    exp_q[6].push_back(d + 37);
    step();
    wait_until(d + 4);
    chk("ps_rem_tick1", rem4[2*W +: W], 1);
    wait_until(d + 18);
    chk("ps_rem_pre_freeze", rem4[2*W +: W], 2);
    en4 = 1'b0;
    wait_until(d + 20);
    chk("ps_rem_frozen_a", rem4[2*W +: W], 2);
    wait_until(d + 23);
    chk("ps_rem_frozen_b", rem4[2*W +: W], 2);
    en4 = 1'b1;
    wait_until(d + 25);
    chk("ps_rem_resume", rem4[2*W +: W], 1);
    wait_until(d + 38);
    stop4[2] = 1'b1;
    step();
    chk("ps_stop_busy", busy4[2], 0);
    wait_until(d + 50);

    // All four channels, mixed modes, then reset mid-count
    d = cyc;
    go1(0, 2, 1'b1);
    go1(1, 3, 1'b0);
    go1(2, 5, 1'b1);
    go1(3, 7, 1'b0);
    exp_q[0].push_back(d + 3);
    exp_q[0].push_back(d + 5);
    exp_q[0].push_back(d + 7);
    exp_q[0].push_back(d + 9);
    exp_q[1].push_back(d + 4);
    exp_q[2].push_back(d + 6);
    exp_q[3].push_back(d + 8);
    step();
    chk("ind_busy", busy1, 4'b1111);
    wait_until(d + 10);
    chk("ind_busy_late", busy1, 4'b0101);
    #1 RST = 1'b1;
    #1;
    chk("rst_fin",  {fin4, fin1}, 0);
    chk("rst_busy", {busy4, busy1}, 0);
    chk("rst_rem",  rem1, 0);
    step(); step();
    RST = 1'b0;
    repeat (15) step();
    chk("post_rst_busy", busy1, 0);
    chk("post_rst_rem", rem1, 0);

    for (int k = 0; k < 8; k++) begin
      if (exp_q[k].size() != 0) begin
        checks++;
        errors++;
        $display("FAIL pending_pulse idx=%0d: %0d pulses outstanding, required 0",
                 k, exp_q[k].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
